// File: rtl/time_set_editor_if.sv
// Purpose : control/data bundle between the mode controller, key debouncers,
//           the time/alarm editor and the 7-segment display driver.
// Latency : none (plain wires). Backpressure: none, keys are levels, tick is a strobe.
// Ports   : master = controller/keys side (drives keys, mode, pos, tick; reads times)
//           slave  = time_set_editor (reads keys, mode, pos, tick; drives times/ring)
interface time_set_editor_if;
   logic        tick_1hz;    // one-cycle strobe, once per second
   logic [1:0]  mode;        // 00 normal, 01 set clock, 10 set alarm, 11 normal
   logic [2:0]  pos;         // digit select 0 h_t .. 5 s_o
   logic        set_inc;     // debounced increment key level
   logic        set_dec;     // debounced decrement key level
   logic        alarm_on;    // alarm enable switch
   logic        alarm_stop;  // stop key level
   logic [23:0] time_bcd;    // {h_t, h_o, m_t, m_o, s_t, s_o}
   logic [15:0] alarm_bcd;   // {h_t, h_o, m_t, m_o}
   logic        alarm_ring;  // alarm sounding

   modport master (
      output tick_1hz, mode, pos, set_inc, set_dec, alarm_on, alarm_stop,
      input  time_bcd, alarm_bcd, alarm_ring
   );

   modport slave (
      input  tick_1hz, mode, pos, set_inc, set_dec, alarm_on, alarm_stop,
      output time_bcd, alarm_bcd, alarm_ring
   );
endinterface

// File: rtl/time_set_editor.sv
// Purpose : holds clock and alarm BCD registers, runs the clock from a 1 Hz
//           strobe, applies digit-wise key edits and drives the alarm ring.
// Latency : key edit, tick advance and ring set/clear are visible one clk after sampling.
// Backpressure: none; a held key yields exactly one edit (rising-edge detect).
// Ports   : clk, rst_n (async, active-low) plus the slave side of time_set_editor_if.
module time_set_editor #(
   parameter int          RING_SECS = 60,
   parameter logic [15:0] ALARM_RST = 16'h0700
) (
   input  logic               clk,
   input  logic               rst_n,
   time_set_editor_if.slave   bus
);

   localparam int             CW        = (RING_SECS < 1) ? 1 : $clog2(RING_SECS + 1);
   localparam logic [CW-1:0]  RING_LOAD = CW'(RING_SECS);

   logic          set_inc_q;
   logic          set_dec_q;
   logic [23:0]   time_q;
   logic [15:0]   alarm_q;
   logic          ring_q;
   logic [CW-1:0] ring_cnt;

   logic          inc_p;
   logic          dec_p;
   logic          edit_vld;
   logic          mode_normal;
   logic          mode_set_clk;
   logic          mode_set_alm;
   logic [23:0]   time_adv;
   logic [23:0]   time_edit;
   logic [15:0]   alarm_edit;
   logic          trigger;
   logic          ring_clear;

   // One-digit wrap-around step. A digit above its limit (only possible
   // transiently) decrements straight to the limit.
   function automatic logic [3:0] step_digit(input logic [3:0] v,
                                             input logic [3:0] max,
                                             input logic       up);
      logic [3:0] r;
      if (up) r = (v >= max) ? 4'd0 : v + 4'd1;
      else    r = (v == 4'd0 || v > max) ? max : v - 4'd1;
      return r;
   endfunction

   // Edit one digit of an {h_t, h_o, m_t, m_o} group; no carries between digits.
   function automatic logic [15:0] edit_hm(input logic [15:0] hm,
                                           input logic [1:0]  p,
                                           input logic        up);
      logic [3:0] ht, ho, mt, mo;
      {ht, ho, mt, mo} = hm;
      case (p)
         2'd0: begin
            ht = step_digit(ht, 4'd2, up);
            // 2x hours only go to 23, so clamp the ones digit in the same edit
            if (ht == 4'd2 && ho > 4'd3) ho = 4'd3;
         end
         2'd1:    ho = step_digit(ho, (ht == 4'd2) ? 4'd3 : 4'd9, up);
         2'd2:    mt = step_digit(mt, 4'd5, up);
         default: mo = step_digit(mo, 4'd9, up);
      endcase
      return {ht, ho, mt, mo};
   endfunction

   // One-second BCD advance with full carry chain, 23:59:59 rolls to 00:00:00.
   function automatic logic [23:0] advance_time(input logic [23:0] t);
      logic [3:0] ht, ho, mt, mo, st, so;
      {ht, ho, mt, mo, st, so} = t;
      if (so != 4'd9) so = so + 4'd1;
      else begin
         so = 4'd0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mo != 4'd9) mo = mo + 4'd1;
            else begin
               mo = 4'd0;
               if (mt != 4'd5) mt = mt + 4'd1;
               else begin
                  mt = 4'd0;
                  if (ht == 4'd2 && ho == 4'd3) begin
                     ht = 4'd0;
                     ho = 4'd0;
                  end else if (ho == 4'd9) begin
                     ho = 4'd0;
                     ht = ht + 4'd1;
                  end else begin
                     ho = ho + 4'd1;
                  end
               end
            end
         end
      end
      return {ht, ho, mt, mo, st, so};
   endfunction

   assign inc_p        = bus.set_inc & ~set_inc_q;
   assign dec_p        = bus.set_dec & ~set_dec_q;
   // Both keys rising together cancel out.
   assign edit_vld     = inc_p ^ dec_p;

   assign mode_set_clk = (bus.mode == 2'b01);
   assign mode_set_alm = (bus.mode == 2'b10);
   assign mode_normal  = ~mode_set_clk & ~mode_set_alm;

   assign time_adv     = advance_time(time_q);

   always_comb begin
      time_edit = time_q;
      case (bus.pos)
         3'd0, 3'd1, 3'd2, 3'd3:
            time_edit[23:8] = edit_hm(time_q[23:8], bus.pos[1:0], inc_p);
         3'd4:    time_edit[7:4] = step_digit(time_q[7:4], 4'd5, inc_p);
         3'd5:    time_edit[3:0] = step_digit(time_q[3:0], 4'd9, inc_p);
         default: time_edit = time_q;
      endcase
   end

   // Alarm has no seconds digits, so pos 4-7 leave it untouched.
   assign alarm_edit = bus.pos[2] ? alarm_q : edit_hm(alarm_q, bus.pos[1:0], inc_p);

   // Compare against the post-increment time so the ring starts on the
   // same tick that displays the alarm minute.
   assign trigger    = mode_normal & bus.tick_1hz & bus.alarm_on &
                       (time_adv == {alarm_q, 8'h00});
   assign ring_clear = bus.alarm_stop | ~bus.alarm_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_inc_q <= 1'b0;
         set_dec_q <= 1'b0;
         time_q    <= 24'h000000;
         alarm_q   <= ALARM_RST;
         ring_q    <= 1'b0;
         ring_cnt  <= '0;
      end else begin
         set_inc_q <= bus.set_inc;
         set_dec_q <= bus.set_dec;

         // Setting the clock freezes it; otherwise it follows the tick.
         if (mode_set_clk) begin
            if (edit_vld) time_q <= time_edit;
         end else if (bus.tick_1hz) begin
            time_q <= time_adv;
         end

         if (mode_set_alm && edit_vld) alarm_q <= alarm_edit;

         // Countdown runs in every mode so a mode change does not stall the ring.
         if (ring_clear) begin
            ring_q   <= 1'b0;
            ring_cnt <= '0;
         end else if (trigger) begin
            ring_q   <= 1'b1;
            ring_cnt <= RING_LOAD;
         end else if (bus.tick_1hz && ring_q) begin
            ring_cnt <= (ring_cnt == '0) ? '0 : ring_cnt - 1'b1;
            if (ring_cnt <= CW'(1)) ring_q <= 1'b0;
         end
      end
   end

   assign bus.time_bcd   = time_q;
   assign bus.alarm_bcd  = alarm_q;
   assign bus.alarm_ring = ring_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Purpose : scoreboard bench for time_set_editor; expectations are queued as
//           stimulus is driven and checked one clk later.
// Latency : one clk per queued expectation. Backpressure: n/a.
module tb_time_set_editor;

   logic clk;
   logic rst_n;

   time_set_editor_if bus();

   time_set_editor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   string       tag_q[$];
   logic [40:0] val_q[$];   // {time, alarm, ring}

   logic [23:0] e_time;
   logic [15:0] e_alarm;
   logic        e_ring;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference: seconds-of-day to BCD by division.
   function automatic logic [23:0] to_bcd(input int s);
      int h, m, c;
      h = s / 3600;
      m = (s / 60) % 60;
      c = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic push_exp(input string tag, input logic [23:0] t, input logic [15:0] a, input logic r);
      tag_q.push_back(tag);
      val_q.push_back({t, a, r});
   endtask

   task automatic step();
      string       tg;
      logic [40:0] v;
      @(posedge clk);
      #1;
      if (val_q.size() != 0) begin
         tg = tag_q.pop_front();
         v  = val_q.pop_front();
         check_val({tg, "_time"},  32'(bus.time_bcd),   32'(v[40:17]));
         check_val({tg, "_alarm"}, 32'(bus.alarm_bcd),  32'(v[16:1]));
         check_val({tg, "_ring"},  32'(bus.alarm_ring), 32'(v[0]));
      end
   endtask

   // Key press for one clk then release for one clk; caller sets e_* first.
   task automatic press(input logic i, input logic d, input string tag);
      bus.set_inc = i;
      bus.set_dec = d;
      push_exp(tag, e_time, e_alarm, e_ring);
      step();
      bus.set_inc = 1'b0;
      bus.set_dec = 1'b0;
      push_exp({tag, "_rel"}, e_time, e_alarm, e_ring);
      step();
   endtask

   task automatic tick_once(input string tag);
      bus.tick_1hz = 1'b1;
      push_exp(tag, e_time, e_alarm, e_ring);
      step();
      bus.tick_1hz = 1'b0;
   endtask

   initial begin
      int    s;
      string tg;
      rst_n          = 1'b0;
      bus.tick_1hz   = 1'b0;
      bus.mode       = 2'b00;
      bus.pos        = 3'd0;
      bus.set_inc    = 1'b0;
      bus.set_dec    = 1'b0;
      bus.alarm_on   = 1'b0;
      bus.alarm_stop = 1'b0;
      e_time  = 24'h000000;
      e_alarm = 16'h0700;
      e_ring  = 1'b0;

      #12;
      check_val("rst_time",  32'(bus.time_bcd),   32'h000000);
      check_val("rst_alarm", 32'(bus.alarm_bcd),  32'h0700);
      check_val("rst_ring",  32'(bus.alarm_ring), 32'h0);
      rst_n = 1'b1;
      step();

      // Full day of ticks in normal mode.
      bus.tick_1hz = 1'b1;
      for (int i = 1; i <= 86400; i++) begin
         s  = i % 86400;
         tg = (s == 36000) ? "carry_0959" :
              (s == 72000) ? "carry_1959" :
              (s == 0)     ? "wrap_2359"  : "sweep";
         push_exp(tg, to_bcd(s), 16'h0700, 1'b0);
         step();
      end
      bus.tick_1hz = 1'b0;

      // Set-clock edits.
      bus.mode = 2'b01;
      bus.pos = 3'd0; e_time = 24'h100000; press(1'b1, 1'b0, "ht_inc");
      bus.pos = 3'd1;
      for (int k = 1; k <= 5; k++) begin
         e_time[19:16] = 4'(k);
         press(1'b1, 1'b0, "ho_inc");
      end
      bus.pos = 3'd0;
      e_time = 24'h230000; press(1'b1, 1'b0, "ht_force_ho3");
      e_time = 24'h030000; press(1'b1, 1'b0, "ht_wrap0");
      e_time = 24'h130000; press(1'b1, 1'b0, "ht_0_to_1");
      e_time = 24'h030000; press(1'b0, 1'b1, "ht_dec");
      bus.pos = 3'd1;
      e_time = 24'h020000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h010000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h000000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h090000; press(1'b0, 1'b1, "ho_dec_wrap9");
      bus.pos = 3'd0;
      e_time = 24'h230000; press(1'b0, 1'b1, "ht_dec_wrap_force");
      bus.pos = 3'd1;
      e_time = 24'h220000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h210000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h200000; press(1'b0, 1'b1, "ho_dec");
      e_time = 24'h230000; press(1'b0, 1'b1, "ho_dec_wrap3");

      bus.tick_1hz = 1'b1;
      repeat (5) begin
         push_exp("frozen", e_time, e_alarm, e_ring);
         step();
      end
      bus.tick_1hz = 1'b0;

      // Held key gives one edit.
      bus.pos = 3'd3;
      bus.set_inc = 1'b1;
      e_time = 24'h230100;
      repeat (10) begin
         push_exp("hold_inc", e_time, e_alarm, e_ring);
         step();
      end
      bus.set_inc = 1'b0;
      push_exp("hold_rel", e_time, e_alarm, e_ring);
      step();

      press(1'b1, 1'b1, "both_keys");
      bus.pos = 3'd6; press(1'b1, 1'b0, "pos6");
      bus.pos = 3'd7; press(1'b0, 1'b1, "pos7");
      bus.pos = 3'd2;
      e_time = 24'h235100; press(1'b0, 1'b1, "mt_dec_wrap");
      e_time = 24'h230100; press(1'b1, 1'b0, "mt_inc_wrap");
      bus.pos = 3'd4; e_time = 24'h230150; press(1'b0, 1'b1, "st_dec_wrap");
      bus.pos = 3'd5; e_time = 24'h230159; press(1'b0, 1'b1, "so_dec_wrap");
      bus.mode = 2'b11; press(1'b1, 1'b0, "mode3_ignore");

      // Set-alarm mode.
      bus.mode = 2'b10;
      e_time = 24'h230200; tick_once("alm_mode_tick");
      bus.pos = 3'd2; e_alarm = 16'h0750; press(1'b0, 1'b1, "alm_mt_dec");
      bus.pos = 3'd4; press(1'b1, 1'b0, "alm_pos4");
      bus.pos = 3'd2; e_alarm = 16'h0700; press(1'b1, 1'b0, "alm_mt_inc_wrap");
      bus.pos = 3'd3; e_alarm = 16'h0701; press(1'b1, 1'b0, "alm_mo_inc");

      // Bring time to 07:00:59.
      bus.mode = 2'b01;
      bus.pos = 3'd0; e_time = 24'h030200; press(1'b1, 1'b0, "to_0700");
      bus.pos = 3'd1;
      for (int k = 4; k <= 7; k++) begin
         e_time[19:16] = 4'(k);
         press(1'b1, 1'b0, "to_0700");
      end
      bus.pos = 3'd3;
      e_time = 24'h070100; press(1'b0, 1'b1, "to_0700");
      e_time = 24'h070000; press(1'b0, 1'b1, "to_0700");
      bus.pos = 3'd4; e_time = 24'h070050; press(1'b0, 1'b1, "to_0700");
      bus.pos = 3'd5; e_time = 24'h070059; press(1'b0, 1'b1, "to_0700");

      // Match, then ring for 60 ticks.
      bus.alarm_on = 1'b1;
      bus.mode = 2'b00;
      e_time = 24'h070100; e_ring = 1'b1;
      tick_once("alarm_match");
      bus.tick_1hz = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         e_time = to_bcd(25260 + k);
         e_ring = (k < 60);
         push_exp((k == 60) ? "ring_end" : "ringing", e_time, e_alarm, e_ring);
         step();
      end
      bus.tick_1hz = 1'b0;

      // Rematch, then stop key.
      bus.mode = 2'b01;
      bus.pos = 3'd3;
      e_time = 24'h070100; press(1'b0, 1'b1, "re_set");
      e_time = 24'h070000; press(1'b0, 1'b1, "re_set");
      bus.pos = 3'd4; e_time = 24'h070050; press(1'b0, 1'b1, "re_set");
      bus.pos = 3'd5; e_time = 24'h070059; press(1'b0, 1'b1, "re_set");
      bus.mode = 2'b00;
      e_time = 24'h070100; e_ring = 1'b1; tick_once("rematch");
      bus.alarm_stop = 1'b1;
      e_ring = 1'b0;
      push_exp("stop_clear", e_time, e_alarm, e_ring);
      step();
      bus.alarm_stop = 1'b0;
      push_exp("stop_rel", e_time, e_alarm, e_ring);
      step();

      // Stop held during a matching tick wins over the trigger.
      bus.mode = 2'b01;
      bus.pos = 3'd5; e_time = 24'h070109; press(1'b0, 1'b1, "prio_set");
      bus.pos = 3'd3; e_time = 24'h070009; press(1'b0, 1'b1, "prio_set");
      bus.pos = 3'd4; e_time = 24'h070059; press(1'b0, 1'b1, "prio_set");
      bus.mode = 2'b00;
      bus.alarm_stop = 1'b1;
      e_time = 24'h070100; tick_once("clear_prio");
      bus.alarm_stop = 1'b0;

      // Ring again, switch to set-clock mid-ring, then async reset.
      bus.mode = 2'b01;
      bus.pos = 3'd5; e_time = 24'h070109; press(1'b0, 1'b1, "m3_set");
      bus.pos = 3'd3; e_time = 24'h070009; press(1'b0, 1'b1, "m3_set");
      bus.pos = 3'd4; e_time = 24'h070059; press(1'b0, 1'b1, "m3_set");
      bus.mode = 2'b00;
      e_time = 24'h070100; e_ring = 1'b1; tick_once("match3");
      bus.mode = 2'b01;
      tick_once("ring_in_set_mode");

      #3;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_time",  32'(bus.time_bcd),   32'h000000);
      check_val("async_rst_alarm", 32'(bus.alarm_bcd),  32'h0700);
      check_val("async_rst_ring",  32'(bus.alarm_ring), 32'h0);
      #10;
      rst_n = 1'b1;
      check_val("sb_drain", 32'(val_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/time_set_editor.md
Name: time_set_editor

Overview:
- Consumes the `mode`/`pos` pair produced by the clock's mode controller and holds the clock and alarm time registers.
- Runs the clock from a 1 Hz enable and applies digit-wise increment/decrement edits at the selected position.
- Raises the alarm ring output on a match.
- Sits between the mode controller / key debouncers and the 7-segment display driver.

Parameters:
- RING_SECS, 60, number of 1 Hz ticks `alarm_ring` stays high after a match.
- ALARM_RST, 16'h0700, reset value of `alarm_bcd` as {h_t, h_o, m_t, m_o} BCD.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- tick_1hz  input  1  one-cycle enable, once per second
- mode  input  2  00 normal, 01 set clock, 10 set alarm, 11 treated as normal
- pos  input  3  digit select: 0 h_t, 1 h_o, 2 m_t, 3 m_o, 4 s_t, 5 s_o
- set_inc  input  1  increment key (debounced level)
- set_dec  input  1  decrement key (debounced level)
- alarm_on  input  1  alarm enable switch
- alarm_stop  input  1  stop key (level)
- time_bcd  output  24  {h_t, h_o, m_t, m_o, s_t, s_o}, 4 bits each
- alarm_bcd  output  16  {h_t, h_o, m_t, m_o}
- alarm_ring  output  1  alarm active

Behaviour:
- Reset values:
  - `time_bcd` = 24'h000000.
  - `alarm_bcd` = ALARM_RST.
  - `alarm_ring` = 0.
  - Key edge registers = 0.
  - Ring counter = 0.
- Edge detection:
  - `inc_p` = set_inc & ~set_inc_q; `dec_p` = set_dec & ~set_dec_q; both history registers are updated every clk.
  - Holding a key produces exactly one edit.
  - An edit is visible on the outputs on the clk edge after the first cycle the key is sampled high.
- Simultaneous `inc_p` and `dec_p`: no edit.
- Digit limits:
  - h_t 0-2.
  - h_o 0-9 when h_t<2, 0-3 when h_t==2.
  - m_t 0-5; m_o 0-9; s_t 0-5; s_o 0-9.
- Edit arithmetic:
  - Increment at the maximum wraps to 0; decrement at 0 wraps to the current maximum.
  - Edits never carry into neighbouring digits.
  - If an h_t edit makes h_t==2 while h_o>3, h_o is forced to 3 in the same cycle.
  - Decrementing h_o at 0 with h_t==2 gives 3.
- Normal mode (00/11):
  - On `tick_1hz`, time advances with BCD carry s_o→s_t→m_o→m_t→h_o→h_t.
  - 23:59:59 → 00:00:00; 09:59:59 → 10:00:00; 19:59:59 → 20:00:00.
  - `inc_p`/`dec_p` are ignored.
- Set-clock mode (01):
  - `tick_1hz` is ignored, so time is frozen.
  - Edits apply to `time_bcd` at `pos`; pos 6/7 give no edit.
- Set-alarm mode (10):
  - Time keeps advancing on ticks.
  - Edits apply to `alarm_bcd` at pos 0-3; pos 4-7 give no edit.
- Alarm match:
  - Trigger condition: in mode 00/11, on the tick cycle where the time after increment equals {alarm_bcd, 8'h00} and alarm_on=1.
  - On trigger, `alarm_ring` is set to 1 and the ring counter is loaded with RING_SECS.
  - Each subsequent tick decrements the counter; `alarm_ring` clears when the counter reaches 0.
  - A retrigger while ringing reloads the counter.
- Alarm clear:
  - `alarm_stop`=1 or `alarm_on`=0 clears `alarm_ring` and the counter on the next clk.
  - Clear has priority over a same-cycle trigger.
- Mode change mid-ring: the ring continues; ticks still count down in any mode.
- Reset mid-operation returns all state to the reset values asynchronously.

Test Plan:
- Reset, mode=00, 86400 ticks → time_bcd goes 000000 → ... → 235959 → 000000; check 095959 → 100000 and 195959 → 200000.
- mode=01, pos=0, time 150000, three set_inc presses → h_t 1→2 with h_o forced to 3 (230000), then 2→0 (030000), then 0→1 (130000); one set_dec at pos=1 from 000000 → 090000; ticks during mode 01 → time unchanged.
- mode=01, set_inc held high 10 cycles → exactly one edit; set_inc and set_dec rising in the same cycle → no change; pos=6 press → no change.
- mode=10, pos=2, alarm 0700, one set_dec → alarm 0750; pos=4 press → no change; time keeps ticking.
- Alarm 0701, time 070059, alarm_on=1, tick → time 070100 and alarm_ring=1; 60 further ticks → ring clears; repeat the match and pulse alarm_stop → ring clears next clk.
- Assert rst_n low mid-ring while in mode 01 → time 000000, alarm 0700, alarm_ring 0 immediately, without waiting for a clk edge.
